data_mem_arbiter: RTL and testbench

//  Shares the single-port 256x16 data memory between requester 0 (CPU controller

---
 rtl/data_mem_arbiter.sv | 120 ++++++++++++
 tb/tb_data_mem_arbiter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter.sv
// Arbiter sharing the single-port data memory between the CPU (requester 0) and
// the program/debug loader (requester 1): owner-keep with burst limit and lock.
module data_mem_arbiter #(
  parameter int AW        = 8,
  parameter int DW        = 16,
  parameter int MAX_BURST = 4
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          Req0,
  input  logic          Req1,
  input  logic          We0,
  input  logic          We1,
  input  logic [AW-1:0] Addr0,
  input  logic [AW-1:0] Addr1,
  input  logic [DW-1:0] WData0,
  input  logic [DW-1:0] WData1,
  input  logic          Lock0,
  input  logic          Lock1,
  output logic          Gnt0,
  output logic          Gnt1,
  output logic          RValid0,
  output logic          RValid1,
  output logic [DW-1:0] RData,
  output logic [AW-1:0] MemAddr,
  output logic          MemWr,
  output logic [DW-1:0] MemWData,
  input  logic [DW-1:0] MemRData,
  output logic [1:0]    OwnerOut
);

  typedef enum logic [1:0] {IDLE = 2'b00, OWN0 = 2'b01, OWN1 = 2'b10} owner_t;

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] MAX_B = BW'(MAX_BURST);

  owner_t        owner;
  logic [BW-1:0] burst_cnt;
  logic          last_gnt;
  logic          grant;
  logic          win;
  logic          same_owner;

  function automatic logic [BW-1:0] sat_inc(input logic [BW-1:0] v);
    return (v == MAX_B) ? MAX_B : v + 1'b1;
  endfunction

  // Winner selection; grants are suppressed while reset is asserted.
  always_comb begin
    grant = 1'b0;
    win   = 1'b0;
    case (owner)
      IDLE: begin
        if (Req0 && Req1) begin
          grant = 1'b1;
          win   = ~last_gnt;
        end else if (Req0 || Req1) begin
          grant = 1'b1;
          win   = Req1;
        end
      end
      OWN0: begin
        if (Req0) begin
          grant = 1'b1;
          win   = ~(Lock0 || !Req1 || (burst_cnt < MAX_B));
        end else if (Req1) begin
          grant = 1'b1;
          win   = 1'b1;
        end
      end
      OWN1: begin
        if (Req1) begin
          grant = 1'b1;
          win   = Lock1 || !Req0 || (burst_cnt < MAX_B);
        end else if (Req0) begin
          grant = 1'b1;
          win   = 1'b0;
        end
      end
      default: begin
        grant = 1'b0;
        win   = 1'b0;
      end
    endcase
    if (!Rst) grant = 1'b0;
  end

  assign Gnt0       = grant & ~win;
  assign Gnt1       = grant & win;
  assign same_owner = win ? (owner == OWN1) : (owner == OWN0);

  assign MemAddr  = Gnt0 ? Addr0  : (Gnt1 ? Addr1  : '0);
  assign MemWData = Gnt0 ? WData0 : (Gnt1 ? WData1 : '0);
  assign MemWr    = (Gnt0 & We0) | (Gnt1 & We1);
  assign RData    = MemRData;
  assign OwnerOut = owner;

  // State update: owner, burst count, last winner and read-valid tracking
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      owner     <= IDLE;
      burst_cnt <= '0;
      last_gnt  <= 1'b1;
      RValid0   <= 1'b0;
      RValid1   <= 1'b0;
    end else begin
      RValid0 <= Gnt0 & ~We0;
      RValid1 <= Gnt1 & ~We1;
      if (grant) begin
        owner     <= win ? OWN1 : OWN0;
        last_gnt  <= win;
        burst_cnt <= same_owner ? sat_inc(burst_cnt) : BW'(1);
      end else begin
        owner     <= IDLE;
        burst_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Randomized and directed bench for data_mem_arbiter against a rule-level
// reference model of ownership, burst limiting, locking and read latency.
module tb_data_mem_arbiter;

  localparam int AW = 8;
  localparam int DW = 16;
  localparam int MAX_BURST = 4;

  logic          Clk = 1'b0;
  logic          Rst = 1'b0;
  logic          Req0 = 1'b0, Req1 = 1'b0, We0 = 1'b0, We1 = 1'b0;
  logic          Lock0 = 1'b0, Lock1 = 1'b0;
  logic [AW-1:0] Addr0 = '0, Addr1 = '0;
  logic [DW-1:0] WData0 = '0, WData1 = '0;
  logic          Gnt0, Gnt1, RValid0, RValid1, MemWr;
  logic [DW-1:0] RData, MemWData;
  logic [DW-1:0] MemRData = '0;
  logic [AW-1:0] MemAddr;
  logic [1:0]    OwnerOut;

  logic [DW-1:0] mem [256];

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  int            m_own = -1;
  int            m_bc = 0;
  int            m_last = 1;
  bit            m_rv0 = 0, m_rv1 = 0;
  logic [DW-1:0] m_rd = '0;

  data_mem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MAX_BURST)) dut (
    .Clk(Clk), .Rst(Rst),
    .Req0(Req0), .Req1(Req1), .We0(We0), .We1(We1),
    .Addr0(Addr0), .Addr1(Addr1), .WData0(WData0), .WData1(WData1),
    .Lock0(Lock0), .Lock1(Lock1),
    .Gnt0(Gnt0), .Gnt1(Gnt1), .RValid0(RValid0), .RValid1(RValid1),
    .RData(RData), .MemAddr(MemAddr), .MemWr(MemWr), .MemWData(MemWData),
    .MemRData(MemRData), .OwnerOut(OwnerOut)
  );

  always #5 Clk = ~Clk;

  // write-first single-port memory with registered read
  always @(posedge Clk) begin
    if (MemWr) mem[MemAddr] <= MemWData;
    MemRData <= MemWr ? MemWData : mem[MemAddr];
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic cyc(input bit rst,
                     input bit r0, input bit w0, input logic [AW-1:0] a0,
                     input logic [DW-1:0] d0, input bit l0,
                     input bit r1, input bit w1, input logic [AW-1:0] a1,
                     input logic [DW-1:0] d1, input bit l1);
    int ew;
    bit rq_own, rq_oth, lk;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    bit ewr;
    @(negedge Clk);
    Rst = rst; Req0 = r0; We0 = w0; Addr0 = a0; WData0 = d0; Lock0 = l0;
    Req1 = r1; We1 = w1; Addr1 = a1; WData1 = d1; Lock1 = l1;
    #1;
    ew = -1;
    if (rst) begin
      if (m_own < 0) begin
        if (r0 && r1) ew = (m_last == 0) ? 1 : 0;
        else if (r0)  ew = 0;
        else if (r1)  ew = 1;
      end else begin
        rq_own = (m_own == 0) ? r0 : r1;
        rq_oth = (m_own == 0) ? r1 : r0;
        lk     = (m_own == 0) ? l0 : l1;
        if (rq_own)      ew = (lk || !rq_oth || m_bc < MAX_BURST) ? m_own : 1 - m_own;
        else if (rq_oth) ew = 1 - m_own;
      end
    end
    ea  = (ew == 0) ? a0 : (ew == 1) ? a1 : '0;
    ed  = (ew == 0) ? d0 : (ew == 1) ? d1 : '0;
    ewr = (ew == 0) ? w0 : (ew == 1) ? w1 : 1'b0;
    check("gnt0", 32'(Gnt0), 32'(ew == 0));
    check("gnt1", 32'(Gnt1), 32'(ew == 1));
    check("memwr", 32'(MemWr), 32'(ewr));
    check("memaddr", 32'(MemAddr), 32'(ea));
    check("memwdata", 32'(MemWData), 32'(ed));
    check("owner", 32'(OwnerOut), (m_own < 0) ? 32'd0 : (m_own == 0) ? 32'd1 : 32'd2);
    check("rvalid0", 32'(RValid0), 32'(m_rv0));
    check("rvalid1", 32'(RValid1), 32'(m_rv1));
    if (m_rv0 || m_rv1) check("rdata", 32'(RData), 32'(m_rd));
    // advance the model to the state after the coming edge
    if (!rst) begin
      m_own = -1; m_bc = 0; m_last = 1; m_rv0 = 0; m_rv1 = 0;
    end else begin
      m_rv0 = (ew == 0) && !w0;
      m_rv1 = (ew == 1) && !w1;
      if (ew >= 0 && !ewr) m_rd = mem[ea];
      if (ew < 0) begin
        m_own = -1; m_bc = 0;
      end else begin
        m_bc   = (ew == m_own) ? ((m_bc + 1 > MAX_BURST) ? MAX_BURST : m_bc + 1) : 1;
        m_own  = ew;
        m_last = ew;
      end
    end
  endtask

  task automatic idle(input bit rst);
    cyc(rst, 0, 0, '0, '0, 0, 0, 0, '0, '0, 0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = DW'($urandom);
    mem[8'h12] = 16'hBEEF;

    // reset held with Req0 pending, then first grant on release
    cyc(0, 1, 0, 8'h00, '0, 0, 0, 0, '0, '0, 0);
    check("t1_gnt0_rst", 32'(Gnt0), 32'd0);
    cyc(0, 1, 0, 8'h00, '0, 0, 0, 0, '0, '0, 0);
    check("t1_owner_rst", 32'(OwnerOut), 32'd0);
    cyc(1, 1, 0, 8'h00, '0, 0, 0, 0, '0, '0, 0);
    check("t1_gnt0_rel", 32'(Gnt0), 32'd1);

    // read of 0x12 returns 0xBEEF one cycle after the grant
    idle(0);
    cyc(1, 1, 0, 8'h12, '0, 0, 0, 0, '0, '0, 0);
    check("t2_gnt0", 32'(Gnt0), 32'd1);
    idle(1);
    check("t2_rvalid0", 32'(RValid0), 32'd1);
    check("t2_rdata", 32'(RData), 32'hBEEF);

    // simultaneous requests out of idle alternate in bursts of MAX_BURST
    idle(0);
    for (int i = 0; i < 2 * MAX_BURST; i++) begin
      cyc(1, 1, 0, 8'(i), '0, 0, 1, 0, 8'(i + 64), '0, 0);
      check("t3_gnt0", 32'(Gnt0), 32'(i < MAX_BURST));
    end

    // locked owner 1 keeps memory past the burst limit
    idle(0);
    cyc(1, 0, 0, '0, '0, 0, 1, 0, 8'h20, '0, 0);
    for (int i = 0; i < 10; i++) begin
      cyc(1, 1, 0, 8'h21, '0, 0, 1, 0, 8'h22, '0, 1);
      check("t4_gnt1_locked", 32'(Gnt1), 32'd1);
    end
    cyc(1, 1, 0, 8'h21, '0, 0, 1, 0, 8'h22, '0, 0);
    check("t4_gnt0_unlock", 32'(Gnt0), 32'd1);

    // write by loader, then CPU read of the same address
    idle(0);
    cyc(1, 0, 0, '0, '0, 0, 1, 1, 8'h34, 16'h00FF, 0);
    check("t5_memwr_n", 32'(MemWr), 32'd1);
    cyc(1, 1, 0, 8'h34, '0, 0, 0, 0, '0, '0, 0);
    check("t5_memwr_n1", 32'(MemWr), 32'd0);
    idle(1);
    check("t5_rvalid0", 32'(RValid0), 32'd1);
    check("t5_rdata", 32'(RData), 32'h00FF);

    // reset right after a read grant drops the pending valid
    cyc(1, 1, 0, 8'h40, '0, 0, 0, 0, '0, '0, 0);
    idle(0);
    idle(1);
    check("t6_rvalid0", 32'(RValid0), 32'd0);
    check("t6_owner", 32'(OwnerOut), 32'd0);

    // randomized traffic over a small address window
    for (int n = 0; n < 600; n++) begin
      cyc(($urandom_range(0, 40) != 0),
          ($urandom_range(0, 3) != 0), $urandom_range(0, 1), AW'($urandom_range(0, 7)),
          DW'($urandom), ($urandom_range(0, 5) == 0),
          ($urandom_range(0, 3) != 0), $urandom_range(0, 1), AW'($urandom_range(0, 7)),
          DW'($urandom), ($urandom_range(0, 5) == 0));
    end
    idle(1);
    idle(1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
